// File: rtl/ccip_if_pkg.sv
// Minimal CCI-P channel-0 types used by the load/writeback stages.
// Field names and encodings follow the CCI-P memory read request/response headers.
package ccip_if_pkg;

  localparam int CCIP_CLADDR_WIDTH = 42;
  localparam int CCIP_CLDATA_WIDTH = 512;
  localparam int CCIP_MDATA_WIDTH  = 16;

  typedef logic [CCIP_CLADDR_WIDTH-1:0] t_ccip_clAddr;
  typedef logic [CCIP_CLDATA_WIDTH-1:0] t_ccip_clData;
  typedef logic [CCIP_MDATA_WIDTH-1:0]  t_ccip_mdata;

  typedef enum logic [1:0] {
    eVC_VA  = 2'b00,
    eVC_VL0 = 2'b01,
    eVC_VH0 = 2'b10,
    eVC_VH1 = 2'b11
  } t_ccip_vc;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eREQ_RDLINE_I = 4'h0,
    eREQ_RDLINE_S = 4'h1
  } t_ccip_c0_req;

  typedef enum logic [3:0] {
    eRSP_RDLINE = 4'h0,
    eRSP_UMSG   = 4'h4
  } t_ccip_c0_rsp;

  typedef struct packed {
    t_ccip_vc     vc_sel;
    logic [1:0]   rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c0_req req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic [1:0]   rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c0_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    t_ccip_clData       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

endpackage

// File: rtl/glm_common.sv
// Types and constants shared by the execute/load/writeback stages:
// BRAM port bundle, operand register map and the common stage state enum.
package glm_common;

  import ccip_if_pkg::*;

  localparam int NUM_REGS        = 8;
  localparam int REG_DRAM_OFFSET = 3;
  localparam int REG_LENGTH      = 4;
  localparam int REG_BRAM_OFFSET = 5;
  localparam int REG_SELECT      = 6;

  localparam int BRAM_ADDR_WIDTH = 16;
  typedef logic [BRAM_ADDR_WIDTH-1:0] t_bram_addr;

  typedef struct packed {
    logic         re;
    t_bram_addr   raddr;
    logic         we;
    t_bram_addr   waddr;
    t_ccip_clData wdata;
  } bram_request;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } t_exec_state;

endpackage

// File: rtl/execute_load.sv
// Streams a contiguous span of host cache lines over CCI-P channel 0 into one of two BRAMs.
// EXECUTE_LOAD_MDATA_TAG_EN: tag reads with their line index so out-of-order responses land correctly.
module execute_load
  import ccip_if_pkg::*;
  import glm_common::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        op_start,
  output logic                        op_done,
  input  logic [NUM_REGS-1:0][31:0]   regs,
  input  t_ccip_clAddr                in_addr,
  input  t_ccip_clAddr                out_addr,
  output bram_request                 memory1_request,
  output bram_request                 memory2_request,
  input  logic                        c0TxAlmFull,
  input  t_if_ccip_c0_Rx              cp2af_sRx_c0,
  output t_if_ccip_c0_Tx              af2cp_sTx_c0
);

  t_exec_state    state_q, state_d;
  t_ccip_clAddr   base_q, base_d;
  logic [15:0]    len_q, len_d;
  logic [15:0]    boff_q, boff_d;
  logic           bsel_q, bsel_d;
  logic [15:0]    req_cnt_q, req_cnt_d;
  logic [15:0]    rsp_cnt_q, rsp_cnt_d;
  logic           op_done_q, op_done_d;
  t_if_ccip_c0_Tx tx_q, tx_d;
  logic           we_q, we_d;
  t_bram_addr     waddr_q, waddr_d;
  t_ccip_clData   wdata_q, wdata_d;

  logic           rsp_ok;
  logic [15:0]    line_idx;

  assign rsp_ok = cp2af_sRx_c0.rspValid && (cp2af_sRx_c0.hdr.resp_type == eRSP_RDLINE);

`ifdef EXECUTE_LOAD_MDATA_TAG_EN
  assign line_idx = cp2af_sRx_c0.hdr.mdata;
`else
  // Arrival order stands in for line order; needs an ordering shim upstream.
  assign line_idx = rsp_cnt_q;
`endif

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    boff_d    = boff_q;
    bsel_d    = bsel_q;
    req_cnt_d = req_cnt_q;
    rsp_cnt_d = rsp_cnt_q;
    op_done_d = 1'b0;
    tx_d      = '0;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;

    case (state_q)
      IDLE: begin
        if (op_start) begin
          base_d    = (regs[REG_SELECT][1] ? out_addr : in_addr)
                      + t_ccip_clAddr'(regs[REG_DRAM_OFFSET]);
          len_d     = regs[REG_LENGTH][15:0];
          boff_d    = regs[REG_BRAM_OFFSET][15:0];
          bsel_d    = regs[REG_SELECT][0];
          req_cnt_d = '0;
          rsp_cnt_d = '0;
          if (regs[REG_LENGTH][15:0] == 16'd0) begin
            state_d = DONE;
          end else begin
            state_d = READ;
          end
        end
      end

      READ: begin
        if ((req_cnt_q < len_q) && !c0TxAlmFull) begin
          tx_d.valid           = 1'b1;
          tx_d.hdr.vc_sel      = eVC_VA;
          tx_d.hdr.cl_len      = eCL_LEN_1;
          tx_d.hdr.req_type    = eREQ_RDLINE_I;
          tx_d.hdr.address     = base_q + t_ccip_clAddr'(req_cnt_q);
`ifdef EXECUTE_LOAD_MDATA_TAG_EN
          tx_d.hdr.mdata       = req_cnt_q;
`endif
          req_cnt_d            = req_cnt_q + 16'd1;
        end

        // Response handling is independent of the request issued this cycle.
        if (rsp_ok) begin
          we_d      = 1'b1;
          waddr_d   = boff_q + line_idx;
          wdata_d   = cp2af_sRx_c0.data;
          rsp_cnt_d = rsp_cnt_q + 16'd1;
          if (rsp_cnt_q == (len_q - 16'd1)) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        op_done_d = 1'b1;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      base_q    <= '0;
      len_q     <= '0;
      boff_q    <= '0;
      bsel_q    <= 1'b0;
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
      op_done_q <= 1'b0;
      tx_q      <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      boff_q    <= boff_d;
      bsel_q    <= bsel_d;
      req_cnt_q <= req_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
      op_done_q <= op_done_d;
      tx_q      <= tx_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  // Write-port demux: both ports see the address/data, only the selected one gets we.
  always_comb begin
    memory1_request       = '0;
    memory2_request       = '0;
    memory1_request.waddr = waddr_q;
    memory1_request.wdata = wdata_q;
    memory1_request.we    = we_q && !bsel_q;
    memory2_request.waddr = waddr_q;
    memory2_request.wdata = wdata_q;
    memory2_request.we    = we_q && bsel_q;
  end

  assign af2cp_sTx_c0 = tx_q;
  assign op_done      = op_done_q;

  logic unused_inputs;
  assign unused_inputs = ^{regs, cp2af_sRx_c0};

endmodule

// File: tb/tb_execute_load.sv
// Directed scoreboard bench for execute_load: expected requests/writes are queued at stimulus
// time and popped as the DUT emits them.
`timescale 1ns/1ps
module tb_execute_load;
  import ccip_if_pkg::*;
  import glm_common::*;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      op_start;
  logic                      op_done;
  logic [NUM_REGS-1:0][31:0] regs;
  t_ccip_clAddr              in_addr;
  t_ccip_clAddr              out_addr;
  bram_request               memory1_request;
  bram_request               memory2_request;
  logic                      c0TxAlmFull;
  t_if_ccip_c0_Rx            rx;
  t_if_ccip_c0_Tx            tx;

  execute_load dut (
    .clk             (clk),
    .reset           (reset),
    .op_start        (op_start),
    .op_done         (op_done),
    .regs            (regs),
    .in_addr         (in_addr),
    .out_addr        (out_addr),
    .memory1_request (memory1_request),
    .memory2_request (memory2_request),
    .c0TxAlmFull     (c0TxAlmFull),
    .cp2af_sRx_c0    (rx),
    .af2cp_sTx_c0    (tx)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    t_ccip_clAddr addr;
    t_ccip_mdata  mdata;
  } req_exp_t;

  typedef struct packed {
    logic         sel;
    logic [15:0]  addr;
    t_ccip_clData data;
  } wr_exp_t;

  req_exp_t req_q[$];
  wr_exp_t  wr_q[$];

  int   cyc = 0;
  int   passed = 0;
  int   failed = 0;
  int   total = 0;
  int   issued = 0;
  int   first_req_cyc = -1;
  int   done_cnt = 0;
  int   done_cyc = -1;
  int   done_before = 0;
  int   op_id = 0;
  int   t_start = 0;
  int   last_rsp = 0;
  logic alm_prev = 1'b0;
  logic        cur_bsel = 1'b0;
  logic [15:0] cur_boff = '0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic t_ccip_clData mkdata(input int op, input int idx);
    t_ccip_clData d;
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = {8'(op), 8'(idx), 8'(w), 8'h5A};
    return d;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic handle_wr(input logic sel, input bram_request r);
    wr_exp_t e;
    $display("[%0d] wr mem%0d addr=%0h", cyc, sel ? 2 : 1, r.waddr);
    check("wr_expected", 512'(wr_q.size() != 0), 512'(1));
    if (wr_q.size() != 0) begin
      e = wr_q.pop_front();
      check("wr_sel", 512'(sel), 512'(e.sel));
      check("wr_addr", 512'(r.waddr), 512'(e.addr));
      check("wr_data", r.wdata, e.data);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  initial forever begin
    req_exp_t e;
    @(negedge clk);
    if (tx.valid) begin
      issued++;
      if (issued == 1) first_req_cyc = cyc;
      $display("[%0d] req addr=%0h mdata=%0h", cyc, tx.hdr.address, tx.hdr.mdata);
      check("req_while_almfull", 512'(alm_prev), 512'(0));
      check("req_hdr", 512'({tx.hdr.vc_sel, tx.hdr.cl_len, tx.hdr.req_type}),
            512'({eVC_VA, eCL_LEN_1, eREQ_RDLINE_I}));
      check("req_expected", 512'(req_q.size() != 0), 512'(1));
      if (req_q.size() != 0) begin
        e = req_q.pop_front();
        check("req_addr", 512'(tx.hdr.address), 512'(e.addr));
        check("req_mdata", 512'(tx.hdr.mdata), 512'(e.mdata));
      end
    end
    if (memory1_request.we) handle_wr(1'b0, memory1_request);
    if (memory2_request.we) handle_wr(1'b1, memory2_request);
    if (op_done) begin
      done_cnt++;
      done_cyc = cyc;
      $display("[%0d] op_done", cyc);
    end
    alm_prev = c0TxAlmFull;
  end

  task automatic start_op(input logic dsel, input logic bsel, input logic [31:0] doff,
                          input logic [15:0] len, input logic [15:0] boff);
    t_ccip_clAddr base;
    regs[REG_DRAM_OFFSET] = doff;
    regs[REG_LENGTH]      = {16'hA5A5, len};
    regs[REG_BRAM_OFFSET] = {16'h0, boff};
    regs[REG_SELECT]      = {30'h0, dsel, bsel};
    base = (dsel ? out_addr : in_addr) + t_ccip_clAddr'(doff);
    op_id++;
    cur_bsel = bsel;
    cur_boff = boff;
    issued = 0;
    first_req_cyc = -1;
    done_before = done_cnt;
    for (int i = 0; i < int'(len); i++) begin
`ifdef EXECUTE_LOAD_MDATA_TAG_EN
      req_q.push_back('{addr: base + t_ccip_clAddr'(i), mdata: 16'(i)});
`else
      req_q.push_back('{addr: base + t_ccip_clAddr'(i), mdata: 16'h0});
`endif
    end
    $display("[%0d] start op %0d len=%0d", cyc, op_id, len);
    op_start = 1'b1;
    t_start = cyc;
    @(posedge clk); #1;
    op_start = 1'b0;
  endtask

  task automatic wait_reqs(input int n);
    int k = 0;
    while (issued < n && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("req_count", 512'(issued), 512'(n));
  endtask

  // idx = line index / mdata tag, k = arrival position within the op.
  task automatic send_rsp(input int idx, input int k, input logic expect_wr);
    t_ccip_clData d;
    d = mkdata(op_id, idx);
    rx = '0;
    rx.rspValid       = 1'b1;
    rx.hdr.resp_type  = eRSP_RDLINE;
    rx.hdr.mdata      = 16'(idx);
    rx.data           = d;
    if (expect_wr) begin
`ifdef EXECUTE_LOAD_MDATA_TAG_EN
      wr_q.push_back('{sel: cur_bsel, addr: cur_boff + 16'(idx), data: d});
`else
      wr_q.push_back('{sel: cur_bsel, addr: cur_boff + 16'(k), data: d});
`endif
    end
    last_rsp = cyc;
    $display("[%0d] rsp idx=%0d", cyc, idx);
    @(posedge clk); #1;
    rx.rspValid = 1'b0;
  endtask

  task automatic send_umsg();
    rx = '0;
    rx.rspValid      = 1'b1;
    rx.hdr.resp_type = eRSP_UMSG;
    rx.data          = mkdata(99, 99);
    $display("[%0d] rsp umsg", cyc);
    @(posedge clk); #1;
    rx.rspValid = 1'b0;
  endtask

  task automatic expect_done(input int exp_cyc);
    repeat (4) @(posedge clk);
    #1;
    check("done_count", 512'(done_cnt), 512'(done_before + 1));
    check("done_cycle", 512'(done_cyc), 512'(exp_cyc));
    check("req_left", 512'(req_q.size()), 512'(0));
    check("wr_left", 512'(wr_q.size()), 512'(0));
  endtask

  initial begin
    reset       = 1'b1;
    op_start    = 1'b0;
    c0TxAlmFull = 1'b0;
    regs        = '0;
    in_addr     = 42'h001_0000_0000;
    out_addr    = 42'h002_ABCD_0000;
    rx          = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_op_done", 512'(op_done), 512'(0));
    check("rst_tx_valid", 512'(tx.valid), 512'(0));
    check("rst_we1", 512'(memory1_request.we), 512'(0));
    check("rst_we2", 512'(memory2_request.we), 512'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic load into memory1; response 0 overlaps request decisions, a UMsg is ignored.
    start_op(1'b0, 1'b0, 32'h10, 16'd4, 16'h20);
    @(posedge clk); #1;
    send_rsp(0, 0, 1'b1);
    wait_reqs(4);
    check("first_req_cycle", 512'(first_req_cyc), 512'(t_start + 2));
    send_rsp(1, 1, 1'b1);
    send_umsg();
    send_rsp(2, 2, 1'b1);
    send_rsp(3, 3, 1'b1);
    expect_done(last_rsp + 2);

`ifdef EXECUTE_LOAD_MDATA_TAG_EN
    // Out-of-order responses into memory2.
    start_op(1'b0, 1'b1, 32'h100, 16'd4, 16'h40);
    wait_reqs(4);
    send_rsp(2, 0, 1'b1);
    send_rsp(0, 1, 1'b1);
    send_rsp(3, 2, 1'b1);
    send_rsp(1, 3, 1'b1);
    expect_done(last_rsp + 2);
`endif

    // Backpressure: almost-full for cycles T+3..T+10, stray op_start while busy.
    start_op(1'b1, 1'b1, 32'h200, 16'd8, 16'h80);
    @(posedge clk); #1;
    @(posedge clk); #1;
    c0TxAlmFull = 1'b1;
    send_rsp(0, 0, 1'b1);
    send_rsp(1, 1, 1'b1);
    op_start = 1'b1;
    @(posedge clk); #1;
    op_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    c0TxAlmFull = 1'b0;
    check("bp_reqs_held", 512'(issued), 512'(2));
    wait_reqs(8);
    for (int i = 2; i < 8; i++) send_rsp(i, i, 1'b1);
    expect_done(last_rsp + 2);

    // Zero length: no traffic, op_done two cycles after the start pulse.
    start_op(1'b0, 1'b0, 32'h0, 16'd0, 16'h0);
    expect_done(t_start + 2);
    check("zero_len_reqs", 512'(issued), 512'(0));

    // Async reset mid-load; wrapping BRAM offset and large DRAM offset.
    start_op(1'b0, 1'b1, 32'h7FFF_FFF0, 16'd6, 16'hFFFF);
    wait_reqs(6);
    send_rsp(0, 0, 1'b1);
    send_rsp(1, 1, 1'b1);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check("async_rst_tx_valid", 512'(tx.valid), 512'(0));
    check("async_rst_we2", 512'(memory2_request.we), 512'(0));
    check("async_rst_op_done", 512'(op_done), 512'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 2; i < 6; i++) send_rsp(i, i, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("rst_no_done", 512'(done_cnt), 512'(done_before));
    check("rst_wr_left", 512'(wr_q.size()), 512'(0));

    // Single-line op after the reset.
    start_op(1'b1, 1'b0, 32'h5, 16'd1, 16'h3);
    wait_reqs(1);
    send_rsp(0, 0, 1'b1);
    expect_done(last_rsp + 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks run", total);
    $fatal(1, "watchdog expired");
  end

endmodule
